// File: rtl/demultiplexor_1x4_stream.sv
// demultiplexor_1x4_stream: routes one input word stream to four registered output channels.
// Optional per-channel accepted-word counters are built when DEMULTIPLEXOR_STATS_EN is defined.
module demultiplexor_1x4_stream #(
    parameter int BIT_WIDTH = 32
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [1:0]           in_select,
    input  logic [BIT_WIDTH-1:0] in_data,
    output logic [3:0]           out_valid,
    input  logic [3:0]           out_ready,
    output logic [BIT_WIDTH-1:0] out_data0,
    output logic [BIT_WIDTH-1:0] out_data1,
    output logic [BIT_WIDTH-1:0] out_data2,
`ifdef DEMULTIPLEXOR_STATS_EN
    output logic [BIT_WIDTH-1:0] out_data3,
    output logic [15:0]          count0,
    output logic [15:0]          count1,
    output logic [15:0]          count2,
    output logic [15:0]          count3
`else
    output logic [BIT_WIDTH-1:0] out_data3
`endif
);
    logic [3:0]           full_q, full_d;
    logic [BIT_WIDTH-1:0] data_q [4];
    logic [BIT_WIDTH-1:0] data_d [4];
    logic                 wr;

    assign in_ready  = reset_n && !flush && (!full_q[in_select] || out_ready[in_select]);
    assign wr        = in_valid && in_ready;
    assign out_valid = full_q;
    assign out_data0 = data_q[0];
    assign out_data1 = data_q[1];
    assign out_data2 = data_q[2];
    assign out_data3 = data_q[3];

    // Per-channel next state: a write fills, an unmatched drain empties, flush empties everything.
    always_comb begin
        full_d = full_q;
        data_d = data_q;
        for (int i = 0; i < 4; i++) begin
            full_d[i] = !flush && ((wr && in_select == 2'(i)) || (full_q[i] && !out_ready[i]));
            data_d[i] = (wr && in_select == 2'(i)) ? in_data : data_q[i];
        end
    end

    // Channel state and data registers; data survives flush, only state is cleared.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            full_q <= '0;
            for (int i = 0; i < 4; i++) data_q[i] <= '0;
        end else begin
            full_q <= full_d;
            data_q <= data_d;
        end
    end

`ifdef DEMULTIPLEXOR_STATS_EN
    logic [15:0] count_q [4];
    logic [15:0] count_d [4];

    assign count0 = count_q[0];
    assign count1 = count_q[1];
    assign count2 = count_q[2];
    assign count3 = count_q[3];

    // Saturating count of accepted words per channel; flush does not touch it.
    always_comb begin
        count_d = count_q;
        for (int i = 0; i < 4; i++)
            count_d[i] = (wr && in_select == 2'(i) && count_q[i] != 16'hFFFF) ? count_q[i] + 16'd1 : count_q[i];
    end

    // Counter registers, cleared only by reset.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 4; i++) count_q[i] <= '0;
        end else begin
            count_q <= count_d;
        end
    end
`endif
endmodule

// File: tb/tb_demultiplexor_1x4_stream.sv
// tb_demultiplexor_1x4_stream: directed self-checking bench for the 1x4 stream demultiplexor.
module tb_demultiplexor_1x4_stream;
    logic        clock = 0;
    logic        reset_n = 0;
    logic        flush = 0;
    logic        in_valid = 0;
    logic        in_ready;
    logic [1:0]  in_select = 0;
    logic [31:0] in_data = 0;
    logic [3:0]  out_valid;
    logic [3:0]  out_ready = 0;
    logic [31:0] out_data0, out_data1, out_data2, out_data3;
`ifdef DEMULTIPLEXOR_STATS_EN
    logic [15:0] count0, count1, count2, count3;
`endif
    int n_cmp = 0;
    int n_err = 0;

    demultiplexor_1x4_stream #(.BIT_WIDTH(32)) dut (
        .clock(clock), .reset_n(reset_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_select(in_select), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data0(out_data0), .out_data1(out_data1), .out_data2(out_data2),
`ifdef DEMULTIPLEXOR_STATS_EN
        .out_data3(out_data3),
        .count0(count0), .count1(count1), .count2(count2), .count3(count3)
`else
        .out_data3(out_data3)
`endif
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        #3;
        check("rst_valid", 32'(out_valid), 32'h0);
        check("rst_ready", 32'(in_ready), 32'h0);
        check("rst_data0", out_data0, 32'h0);
        #4 reset_n = 1;
        tick();

        in_select = 1; in_data = 32'hDEADBEEF; in_valid = 1; out_ready = 4'b0000;
        #1 check("route_ready", 32'(in_ready), 32'h1);
        tick();
        in_valid = 0;
        check("route_valid", 32'(out_valid), 32'h2);
        for (int k = 0; k < 5; k++) begin
            tick();
            check("route_hold_v", 32'(out_valid), 32'h2);
            check("route_hold_d", out_data1, 32'hDEADBEEF);
        end

        in_select = 3; in_data = 32'h33; in_valid = 1;
        tick();
        in_valid = 0;
        check("bp_fill3", 32'(out_valid), 32'hA);
        in_select = 3; in_data = 32'hA0; in_valid = 1;
        #1 check("bp_blocked", 32'(in_ready), 32'h0);
        in_select = 0;
        #1 check("bp_other", 32'(in_ready), 32'h1);
        tick();
        in_valid = 0;
        check("bp_valid", 32'(out_valid), 32'hB);
        check("bp_data0", out_data0, 32'hA0);
        check("bp_data3", out_data3, 32'h33);

        out_ready = 4'b1111;
        tick();
        check("drain_all", 32'(out_valid), 32'h0);

        in_select = 2;
        for (int k = 1; k <= 8; k++) begin
            in_data = 32'(k); in_valid = 1;
            #1 check("tp_ready", 32'(in_ready), 32'h1);
            tick();
            check("tp_valid", 32'(out_valid), 32'h4);
            check("tp_data", out_data2, 32'(k));
        end
        in_valid = 0;
        tick();
        check("tp_empty", 32'(out_valid), 32'h0);

        out_ready = 4'b0000;
        in_select = 0; in_data = 32'h1; in_valid = 1;
        tick();
        in_select = 1; in_data = 32'h2;
        tick();
        in_valid = 0;
        check("fl_fill", 32'(out_valid), 32'h3);
        flush = 1; in_valid = 1; in_select = 2; in_data = 32'h77;
        #1 check("fl_ready", 32'(in_ready), 32'h0);
        tick();
        flush = 0; in_valid = 0;
        check("fl_valid", 32'(out_valid), 32'h0);
        check("fl_nodeliver", out_data2, 32'h8);

        in_select = 2; in_data = 32'h55; in_valid = 1;
        tick();
        in_valid = 0;
        check("mr_fill2", 32'(out_valid), 32'h4);
        #2 reset_n = 0;
        #1;
        check("mr_valid", 32'(out_valid), 32'h0);
        check("mr_ready", 32'(in_ready), 32'h0);
        check("mr_data2", out_data2, 32'h0);
        #2 reset_n = 1;
        in_select = 0; in_data = 32'h9; in_valid = 1;
        tick();
        in_valid = 0;
        check("mr_first", 32'(out_valid), 32'h1);
        check("mr_first_d", out_data0, 32'h9);

`ifdef DEMULTIPLEXOR_STATS_EN
        out_ready = 4'b1111; in_select = 0; in_valid = 1;
        for (int k = 0; k < 65540; k++) tick();
        in_valid = 0;
        check("st_c0", 32'(count0), 32'hFFFF);
        check("st_c1", 32'(count1), 32'h0);
        check("st_c2", 32'(count2), 32'h0);
        check("st_c3", 32'(count3), 32'h0);
        flush = 1;
        tick();
        flush = 0;
        check("st_flush", 32'(count0), 32'hFFFF);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/demultiplexor_1x4_stream.md
DEMULTIPLEXOR_1X4_STREAM -- requirements
Module: demultiplexor_1x4_stream

Interface
REQ-001 Parameter BIT_WIDTH, default 32, data word width in bits.
REQ-002 clock  input  1  single clock; all state updates on rising edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 flush  input  1  synchronous clear of all buffered words.
REQ-005 in_valid  input  1  input word present.
REQ-006 in_ready  output  1  block accepts input word this cycle.
REQ-007 in_select  input  2  destination channel 0..3 for the input word.
REQ-008 in_data  input  BIT_WIDTH  input word.
REQ-009 out_valid  output  4  per-channel word present, bit i = channel i.
REQ-010 out_ready  input  4  per-channel consumer accepts, bit i = channel i.
REQ-011 out_data0..out_data3  output  BIT_WIDTH each  per-channel word.
REQ-012 count0..count3  output  16 each  per-channel accepted-word counter (only with STATS macro, REQ-031).

Function
REQ-013 Each channel SHALL hold a one-entry output register with state EMPTY or FULL; out_valid[i] = (state i == FULL).
REQ-014 Transfer rule SHALL be: input handshake when in_valid && in_ready; channel i handshake when out_valid[i] && out_ready[i].
REQ-015 in_ready SHALL be !flush && (state[in_select] == EMPTY || out_ready[in_select]); combinational, independent of in_valid.
REQ-016 On input handshake, in_data SHALL be written to channel in_select register; latency in_valid->out_valid exactly 1 cycle.
REQ-017 Channel i transitions: EMPTY->FULL on write; FULL->EMPTY on output handshake without write; FULL->FULL with new data on simultaneous output handshake and write (full throughput, 1 word/cycle).
REQ-018 Non-selected channels SHALL be unaffected by input handshakes; all four channels MAY drain in the same cycle.
REQ-019 out_data[i] SHALL remain stable while out_valid[i] && !out_ready[i].
REQ-020 in_select out of range is impossible (2 bits cover 0..3); no error path.
REQ-021 Blocking: FULL channel with out_ready low SHALL deassert in_ready only when in_select targets it; no head-of-line effect on other channels beyond the single shared input.
REQ-022 flush high SHALL set all channels EMPTY on the next edge, force in_ready low, discard any concurrent input word; output handshakes in the flush cycle still complete.
REQ-023 out_data registers SHALL NOT be required to clear on flush; only state clears.
REQ-024 Data path SHALL pass BIT_WIDTH bits unmodified; no width conversion.

Reset
REQ-025 reset_n low SHALL immediately, without clock, force all channels EMPTY: out_valid = 4'b0000.
REQ-026 During reset out_data0..3 SHALL read 0; count0..3 SHALL read 0.
REQ-027 in_ready SHALL be 0 while reset_n is low.
REQ-028 Reset asserted mid-transfer SHALL discard buffered words; first accept possible on first rising edge after reset_n deasserts.

Configuration
REQ-029 Macro DEMULTIPLEXOR_STATS_EN SHALL control per-channel counters.
REQ-030 Without macro: count0..3 ports absent; no counter logic.
REQ-031 With macro: count[i] increments by 1 per input handshake to channel i, saturates at 16'hFFFF, cleared by reset only (not by flush).

Verification
REQ-032 Reset: reset_n=0 mid-run with channel 2 FULL -> out_valid=0000, in_ready=0, out_data2=0 without clock edge.
REQ-033 Routing: in_select=1, in_data=32'hDEADBEEF, in_valid=1 one cycle, out_ready=0000 -> next cycle out_valid=0010, out_data1=DEADBEEF held stable 5 cycles.
REQ-034 Backpressure: channel 3 FULL, out_ready[3]=0, in_select=3 -> in_ready=0; change in_select=0 -> in_ready=1, word lands in channel 0.
REQ-035 Throughput: in_select=2, 8 consecutive words 1..8, out_ready=1111 -> out_data2 shows 1..8 on 8 consecutive cycles, in_ready never low.
REQ-036 Flush: channels 0,1 FULL, flush=1 with in_valid=1 -> in_ready=0, next cycle out_valid=0000, input word not delivered.
REQ-037 Stats (DEMULTIPLEXOR_STATS_EN): 65540 words to channel 0 -> count0=FFFF, count1..3=0; flush leaves count0=FFFF.
